iter_muldiv_unit: RTL and testbench
===================================

Name: iter_muldiv_unit

Overview:
- Multi-cycle integer multiply/divide execution unit for the next-generation (multi-cycle and pipelined) ARM CPU.
- Replaces the combinational multiplier. Adds unsigned and signed divide, a start/done handshake so the core can stall, and a full double-width product.
- Sits beside the ALU. Operands come from register-file ports Da/Db; results go to the writeback mux.

Parameters:
WIDTH, 64, operand width in bits; must be even and >= 8.
UNROLL, 1, bits retired per RUN cycle; must divide WIDTH; N = WIDTH/UNROLL.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled only in IDLE
op  input  2  00 MUL unsigned, 01 MUL signed, 10 UDIV, 11 SDIV; sampled with start
A  input  WIDTH  multiplicand / dividend; sampled with start
B  input  WIDTH  multiplier / divisor; sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; results valid and stable from this cycle
result_lo  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
result_hi  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
div_by_zero  output  1  valid with done; DIV op with B==0
overflow  output  1  valid with done; SDIV with A=MIN, B=-1

Behaviour:
- Reset (reset==0, asynchronous, any state):
  - state=IDLE, counter=0.
  - busy, done, result_lo, result_hi, div_by_zero, overflow all 0.
  - An in-flight operation is discarded. No partial result appears after reset releases.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - start==1 at edge E0: latch op, A, B; take magnitudes for signed ops; record the sign of each operand; clear the accumulator; counter=0; go to RUN.
  - start==0: hold.
- RUN:
  - MUL: shift-add, UNROLL multiplier bits per cycle.
  - DIV: restoring divide, UNROLL quotient bits per cycle.
  - counter increments each edge. At the edge where counter reaches N-1, go to FIX. RUN lasts exactly N cycles.
- FIX (1 cycle) applies sign correction:
  - Signed MUL: negate the 2*WIDTH product when the operand signs differ.
  - SDIV: quotient negated when the signs differ (truncate toward zero); remainder takes the sign of the dividend.
  - Results and flags are registered into the output registers; go to DONE.
- DONE (1 cycle): done=1, then IDLE unconditionally.
- Latency: done is high in the cycle following edge E0+N+1, for all ops and operands.
  - Timing is fixed and data-independent, so the core's stall count is a constant N+2.
- start while busy (RUN/FIX/DONE): ignored, no queuing. A, B and op may change freely while busy.
- Results hold their last values after DONE until the FIX of the next operation. They read 0 after reset.
- Boundary rules:
  - Divide by zero (UDIV or SDIV, B==0): quotient=0, remainder=A (original, unsigned or signed as given), div_by_zero=1, overflow=0. Full latency still applies.
  - SDIV with A=MIN (1 followed by zeros) and B=-1: quotient=MIN, remainder=0, overflow=1.
  - MUL ops: div_by_zero=0, overflow=0. The product is exact in 2*WIDTH bits.
  - Signed MUL with MIN*MIN: hi=0x4000..0, lo=0.
  - Flags are cleared at every FIX, not sticky.
- start asserted in the same cycle reset deasserts: sampled normally at the first rising edge with reset==1.

Test Plan:
1. WIDTH=64, UNROLL=1, op=01, A=-3, B=5, start pulsed at E0 -> busy rises after E0; done high in the cycle after E0+65 (66th cycle); lo=0xFFFFFFFFFFFFFFF1, hi=0xFFFFFFFFFFFFFFFF; flags 0.
2. op=00, A=0xFFFFFFFFFFFFFFFF, B=2 -> lo=0xFFFFFFFFFFFFFFFE, hi=0x1; repeat with op=01 -> lo=0xFFFFFFFFFFFFFFFE, hi=0xFFFFFFFFFFFFFFFF.
3. op=11, A=-7, B=2 -> lo=0xFFFFFFFFFFFFFFFD (-3), hi=0xFFFFFFFFFFFFFFFF (-1); op=10, A=100, B=7 -> lo=14, hi=2.
4. op=10, A=100, B=0 -> lo=0, hi=100, div_by_zero=1, done at the normal 66-cycle latency; op=11, A=0x8000000000000000, B=-1 -> lo=0x8000000000000000, hi=0, overflow=1.
5. Start an op, then pulse start with new operands at cycles 10 and 65 (busy) -> ignored; exactly one done; results match the first operands; the next start in IDLE accepted.
6. Assert reset (0) mid-RUN at cycle 30 -> busy, done, results and flags 0 immediately, without waiting for a clock edge; release, run UNROLL=4 build with op=00, A=6, B=7 -> lo=42, hi=0, done in the cycle after E0+17.

Source files
------------

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle integer multiply/divide unit: shift-add multiply and restoring divide,
// fixed N+2 cycle latency with a start/busy/done handshake and sign fix-up stage.
module iter_muldiv_unit #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / UNROLL;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  a_orig_q, a_orig_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              b_zero_q, b_zero_d;
  logic              sdiv_ovf_q, sdiv_ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_lo_q, result_lo_d;
  logic [WIDTH-1:0]  result_hi_q, result_hi_d;
  logic              div_by_zero_q, div_by_zero_d;
  logic              overflow_q, overflow_d;

  logic              in_sign_a, in_sign_b;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [W2-1:0]     step_acc;
  logic [W2:0]       mul_t;
  logic [WIDTH:0]    div_r;
  logic [W2-1:0]     prod;
  logic [WIDTH-1:0]  quo, rem;

  // Operand magnitudes and signs; only op[0]=1 (signed) ops look at sign bits.
  always_comb begin
    in_sign_a = op[0] & A[WIDTH-1];
    in_sign_b = op[0] & B[WIDTH-1];
    a_mag     = in_sign_a ? (~A + WIDTH'(1)) : A;
    b_mag     = in_sign_b ? (~B + WIDTH'(1)) : B;
  end

  // One RUN cycle: acc = {hi/rem, lo/multiplier-or-dividend}, opnd = multiplicand/divisor.
  always_comb begin
    step_acc = acc_q;
    mul_t    = '0;
    div_r    = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (!op_q[1]) begin
        mul_t = {1'b0, step_acc};
        if (mul_t[0]) mul_t[W2:WIDTH] = mul_t[W2:WIDTH] + (WIDTH+1)'(opnd_q);
        step_acc = mul_t[W2:1];
      end else begin
        div_r = {step_acc[W2-1:WIDTH], step_acc[WIDTH-1]};
        step_acc[WIDTH-1:0] = {step_acc[WIDTH-2:0], 1'b0};
        if (div_r >= (WIDTH+1)'(opnd_q)) begin
          div_r       = div_r - (WIDTH+1)'(opnd_q);
          step_acc[0] = 1'b1;
        end
        step_acc[W2-1:WIDTH] = div_r[WIDTH-1:0];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    acc_d         = acc_q;
    opnd_d        = opnd_q;
    a_orig_d      = a_orig_q;
    sign_a_d      = sign_a_q;
    sign_b_d      = sign_b_q;
    b_zero_d      = b_zero_q;
    sdiv_ovf_d    = sdiv_ovf_q;
    done_d        = 1'b0;
    result_lo_d   = result_lo_q;
    result_hi_d   = result_hi_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    prod          = acc_q;
    quo           = acc_q[WIDTH-1:0];
    rem           = acc_q[W2-1:WIDTH];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          a_orig_d   = A;
          sign_a_d   = in_sign_a;
          sign_b_d   = in_sign_b;
          b_zero_d   = (B == '0);
          sdiv_ovf_d = (op == 2'b11) && (A == MIN_VAL) && (B == '1);
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          cnt_d      = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        div_by_zero_d = 1'b0;
        overflow_d    = 1'b0;
        if (!op_q[1]) begin
          if (op_q[0] && (sign_a_q ^ sign_b_q)) prod = ~acc_q + W2'(1);
          result_lo_d = prod[WIDTH-1:0];
          result_hi_d = prod[W2-1:WIDTH];
        end else if (b_zero_q) begin
          result_lo_d   = '0;
          result_hi_d   = a_orig_q;
          div_by_zero_d = 1'b1;
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          if (op_q[0] && (sign_a_q ^ sign_b_q)) quo = ~acc_q[WIDTH-1:0] + WIDTH'(1);
          if (op_q[0] && sign_a_q) rem = ~acc_q[W2-1:WIDTH] + WIDTH'(1);
          result_lo_d = quo;
          result_hi_d = rem;
          overflow_d  = sdiv_ovf_q;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      acc_q         <= '0;
      opnd_q        <= '0;
      a_orig_q      <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      b_zero_q      <= 1'b0;
      sdiv_ovf_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_lo_q   <= '0;
      result_hi_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      acc_q         <= acc_d;
      opnd_q        <= opnd_d;
      a_orig_q      <= a_orig_d;
      sign_a_q      <= sign_a_d;
      sign_b_q      <= sign_b_d;
      b_zero_q      <= b_zero_d;
      sdiv_ovf_q    <= sdiv_ovf_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_lo_q   <= result_lo_d;
      result_hi_q   <= result_hi_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = result_lo_q;
  assign result_hi   = result_hi_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit: UNROLL=1 and UNROLL=4 instances checked
// against a wide-arithmetic reference model, including latency and reset behaviour.
module tb_iter_muldiv_unit;

  localparam int unsigned W  = 64;
  localparam int unsigned N1 = 64;
  localparam int unsigned N4 = 16;
  localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         start1, start4;
  logic [1:0]   op;
  logic [W-1:0] A, B;
  logic         busy1, done1, dbz1, ovf1;
  logic [W-1:0] lo1, hi1;
  logic         busy4, done4, dbz4, ovf4;
  logic [W-1:0] lo4, hi4;

  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t q1[$];
  exp_t q4[$];

  iter_muldiv_unit #(.WIDTH(W), .UNROLL(1)) u_dut1 (
    .clk(clk), .reset(reset_n), .start(start1), .op(op), .A(A), .B(B),
    .busy(busy1), .done(done1), .result_lo(lo1), .result_hi(hi1),
    .div_by_zero(dbz1), .overflow(ovf1)
  );

  iter_muldiv_unit #(.WIDTH(W), .UNROLL(4)) u_dut4 (
    .clk(clk), .reset(reset_n), .start(start4), .op(op), .A(A), .B(B),
    .busy(busy4), .done(done4), .result_lo(lo4), .result_hi(hi4),
    .div_by_zero(dbz4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain wide arithmetic, SV signed division semantics.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0]        p;
    logic signed [2*W-1:0] sa, sb;
    logic signed [W-1:0]   ssa, ssb;
    e.lo = '0; e.hi = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.cyc = 0;
    ssa = $signed(a);
    ssb = $signed(b);
    case (o)
      2'b00: begin
        p = {64'd0, a} * {64'd0, b};
        e.lo = p[W-1:0]; e.hi = p[2*W-1:W];
      end
      2'b01: begin
        sa = 128'(ssa);
        sb = 128'(ssb);
        p = sa * sb;
        e.lo = p[W-1:0]; e.hi = p[2*W-1:W];
      end
      2'b10: begin
        if (b == '0) begin e.hi = a; e.dbz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: begin
        if (b == '0) begin e.hi = a; e.dbz = 1'b1; end
        else if (a == MINV && b == '1) begin e.lo = MINV; e.ovf = 1'b1; end
        else begin e.lo = ssa / ssb; e.hi = ssa % ssb; end
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_done(input int which, input logic [W-1:0] lo, input logic [W-1:0] hi,
                            input logic dbz, input logic ovf);
    exp_t e;
    if ((which == 1 && q1.size() == 0) || (which == 4 && q4.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_done dut%0d: got done=1 expected no done (cycle %0d)", which, cyc);
      return;
    end
    if (which == 1) e = q1.pop_front();
    else            e = q4.pop_front();
    chk($sformatf("dut%0d result_lo", which), lo, e.lo);
    chk($sformatf("dut%0d result_hi", which), hi, e.hi);
    chk($sformatf("dut%0d div_by_zero", which), 64'(dbz), 64'(e.dbz));
    chk($sformatf("dut%0d overflow", which), 64'(ovf), 64'(e.ovf));
    chk($sformatf("dut%0d done_cycle", which), 64'(cyc), 64'(e.cyc));
  endtask

  // Monitor: every done pulse is matched against the head of its queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done1) check_done(1, lo1, hi1, dbz1, ovf1);
      if (done4) check_done(4, lo4, hi4, dbz4, ovf4);
    end
  end

  task automatic issue(input int which, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    op = o; A = a; B = b;
    e = model(o, a, b);
    e.cyc = cyc + ((which == 1) ? int'(N1) : int'(N4)) + 2;
    if (which == 1) begin q1.push_back(e); start1 = 1'b1; end
    else            begin q4.push_back(e); start4 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    chk($sformatf("dut%0d busy_after_start", which), 64'((which == 1) ? busy1 : busy4), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q4.size() == 0 && !busy1 && !busy4) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_idle: got pending=%0d/%0d expected 0/0", q1.size(), q4.size());
    q1.delete();
    q4.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy1"}, 64'(busy1), 64'd0);
    chk({tag, " done1"}, 64'(done1), 64'd0);
    chk({tag, " lo1"}, lo1, 64'd0);
    chk({tag, " hi1"}, hi1, 64'd0);
    chk({tag, " dbz1"}, 64'(dbz1), 64'd0);
    chk({tag, " ovf1"}, 64'(ovf1), 64'd0);
    chk({tag, " busy4"}, 64'(busy4), 64'd0);
    chk({tag, " lo4"}, lo4, 64'd0);
    chk({tag, " hi4"}, hi4, 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = '1;
      2: v = MINV;
      3: v = 64'($urandom_range(0, 20));
      4: v = -64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  logic [1:0]   d_op [9] = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11};
  logic [W-1:0] d_a  [9] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100, MINV, MINV, 64'hFFFF_FFFF_FFFF_FFF9};
  logic [W-1:0] d_b  [9] = '{64'd5, 64'd2, 64'd2, 64'd2, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, MINV, 64'd0};

  initial begin
    n_cmp = 0; n_err = 0;
    reset_n = 1'b0; start1 = 1'b0; start4 = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(1, d_op[i], d_a[i], d_b[i]);
      wait_idle();
    end

    // Starts while busy (sampled at E0+10 and E0+65) must be ignored.
    begin
      int c0;
      issue(1, 2'b10, 64'd1000, 64'd33);
      c0 = cyc;
      while (cyc < c0 + 9) @(negedge clk);
      op = 2'b00; A = 64'd5; B = 64'd9; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; A = 64'hDEAD; B = 64'hBEEF;
      while (cyc < c0 + 64) @(negedge clk);
      op = 2'b01; A = 64'd11; B = 64'd13; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_idle();
      issue(1, 2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
      wait_idle();
    end

    for (int i = 0; i < 30; i++) begin
      issue(1, 2'($urandom_range(0, 3)), rnd_val(), rnd_val());
      wait_idle();
    end
    for (int i = 0; i < 15; i++) begin
      issue(4, 2'($urandom_range(0, 3)), rnd_val(), rnd_val());
      wait_idle();
    end

    // Asynchronous reset mid-RUN discards the operation immediately.
    issue(1, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0001);
    repeat (28) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("midrun_reset");
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    // Start asserted in the same cycle reset releases.
    begin
      exp_t e;
      reset_n = 1'b1;
      op = 2'b00; A = 64'd6; B = 64'd7;
      e = model(2'b00, 64'd6, 64'd7);
      e.cyc = cyc + int'(N4) + 2;
      q4.push_back(e);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      chk("dut4 busy_after_reset_start", 64'(busy4), 64'd1);
      wait_idle();
      chk("dut1 lo_after_reset", lo1, 64'd0);
      chk("dut1 busy_after_reset", 64'(busy1), 64'd0);
    end

    repeat (4) @(negedge clk);
    if (q1.size() != 0 || q4.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover_expectations: got %0d/%0d expected 0/0", q1.size(), q4.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
